// File: rtl/data_mem_responder.sv
// data_mem_responder: responder end of the processor data-memory port.
// One load/store in flight at a time; the processor is held with stall while
// the on-chip array is accessed after LATENCY cycles, then a one-cycle
// rsp_valid pulse returns load data / the out-of-range flag.
// Optional feature macro: BTN_MMIO_EN adds a 4-bit button port mapped as a
// read-only MMIO word at BTN_ADDR (synchronized level + sticky rise bits).
module data_mem_responder #(
  parameter int DATA_W  = 24,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
`ifdef BTN_MMIO_EN
  ,
  parameter logic [ADDR_W-1:0] BTN_ADDR = ADDR_W'(16'hFFFF)
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
`ifdef BTN_MMIO_EN
  ,
  input  logic [3:0]        btn
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = 4;
  // Full-width depth so the range compare never wraps on high address bits.
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              done;
  logic              in_range;
  logic              btn_hit;
  logic [DATA_W-1:0] rd;

  assign stall    = ((state == IDLE) && req_valid) || (state == BUSY);
  // Completion edge; a reset on the same edge aborts the access.
  assign done     = (state == BUSY) && (cnt == '0) && !reset;
  assign in_range = ({1'b0, addr_q} < DEPTH_W);

`ifdef BTN_MMIO_EN
  logic [3:0] btn_m, btn_s, btn_d, press;
  logic       press_clr;

  assign btn_hit   = (addr_q == BTN_ADDR);
  assign press_clr = done && !we_q && btn_hit;

  // Two-flop synchronizer, one more stage for rise detect, sticky press bits.
  // A rise landing on the clearing edge wins over the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_m <= '0;
      btn_s <= '0;
      btn_d <= '0;
      press <= '0;
    end else begin
      btn_m <= btn;
      btn_s <= btn_m;
      btn_d <= btn_s;
      press <= (press & ~{4{press_clr}}) | (btn_s & ~btn_d);
    end
  end

  // Read mux: button word first, then array, else zero.
  always_comb begin
    rd = '0;
    if (btn_hit)       rd = DATA_W'({press, btn_s});
    else if (in_range) rd = mem[addr_q[IDX_W-1:0]];
  end
`else
  assign btn_hit = 1'b0;

  // Read mux: array word when in range, zero otherwise.
  always_comb begin
    rd = '0;
    if (in_range) rd = mem[addr_q[IDX_W-1:0]];
  end
`endif

  // Request FSM: capture in IDLE, count down in BUSY, register the response.
  // A request raised during the response cycle is accepted on the next edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt     <= CNT_W'(LATENCY - 1);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state     <= IDLE;
            rsp_valid <= 1'b1;
            rsp_err   <= !btn_hit && !in_range;
            if (!we_q) rsp_rdata <= rd;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array write: in-range stores only; contents survive reset.
  always_ff @(posedge clk) begin
    if (done && we_q && in_range && !btn_hit)
      mem[addr_q[IDX_W-1:0]] <= wdata_q;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: three instances at LATENCY 2, 1, 4.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        rv   [3];
  logic        rwe  [3];
  logic [15:0] ra   [3];
  logic [23:0] rwd  [3];
  logic        stall[3];
  logic        rvld [3];
  logic [23:0] rdat [3];
  logic        rerr [3];
`ifdef BTN_MMIO_EN
  logic [3:0]  btn;
`endif

  int ntot  = 0;
  int npass = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_responder #(
      .DATA_W (24),
      .ADDR_W (16),
      .DEPTH  (1024),
      .LATENCY((g == 0) ? 2 : (g == 1) ? 1 : 4)
    ) u_dut (
      .clk      (clk),
      .reset    (rst),
      .req_valid(rv[g]),
      .req_we   (rwe[g]),
      .req_addr (ra[g]),
      .req_wdata(rwd[g]),
      .stall    (stall[g]),
      .rsp_valid(rvld[g]),
      .rsp_rdata(rdat[g]),
      .rsp_err  (rerr[g])
`ifdef BTN_MMIO_EN
      ,
      .btn      (btn)
`endif
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Called at a negedge: present a request and wait for its response.
  // k = negedges from drive to rsp_valid, nst = stall-high negedges before it.
  task automatic xfer(input int u, input logic we, input logic [15:0] a,
                      input logic [23:0] d, output logic [23:0] rdata,
                      output logic err, output int k, output int nst);
    logic seen;
    rv[u] = 1'b1; rwe[u] = we; ra[u] = a; rwd[u] = d;
    #1 chk("stall_req", stall[u], 1'b1);
    k = 0; nst = 0; seen = 1'b0; rdata = '0; err = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (rvld[u]) begin
        seen  = 1'b1;
        rdata = rdat[u];
        err   = rerr[u];
      end else begin
        nst += int'(stall[u]);
      end
    end
    chk("rsp_timeout", seen, 1'b1);
  endtask

  // Drop the request, confirm stall falls and the response was one cycle.
  task automatic idle(input int u);
    rv[u] = 1'b0;
    #1 chk("stall_idle", stall[u], 1'b0);
    @(negedge clk);
    chk("rsp_pulse", rvld[u], 1'b0);
  endtask

  initial begin
    logic [23:0] d;
    logic        e;
    int          k, n, acc;
    for (int i = 0; i < 3; i++) begin
      rv[i] = 1'b0; rwe[i] = 1'b0; ra[i] = '0; rwd[i] = '0;
    end
`ifdef BTN_MMIO_EN
    btn = '0;
`endif
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_stall", stall[0], 1'b0);
    chk("rst_valid", rvld[0], 1'b0);
    chk("rst_err",   rerr[0], 1'b0);
    chk("rst_rdata", rdat[0], 24'h0);
    rst = 1'b0;
    @(negedge clk);

    // store then load, LATENCY 2
    xfer(0, 1'b1, 16'd5, 24'hABCDEF, d, e, k, n);
    chk("st5_lat", k, 3); chk("st5_stall", n, 2); chk("st5_err", e, 1'b0);
    idle(0);
    xfer(0, 1'b0, 16'd5, 24'h0, d, e, k, n);
    chk("ld5_lat", k, 3); chk("ld5_stall", n, 2);
    chk("ld5_data", d, 24'hABCDEF); chk("ld5_err", e, 1'b0);
    idle(0);
    xfer(0, 1'b1, 16'd6, 24'h000066, d, e, k, n);
    chk("st_holds_rdata", rdat[0], 24'hABCDEF);
    idle(0);

    // back-to-back: next request raised in each response cycle
    xfer(0, 1'b1, 16'd1, 24'h0, d, e, k, n);
    idle(0);
    acc = 0;
    xfer(0, 1'b1, 16'd0, 24'h1, d, e, k, n); acc += k;
    chk("b2b_rsp1_at", acc, 3);
    xfer(0, 1'b0, 16'd0, 24'h0, d, e, k, n); acc += k;
    chk("b2b_rsp2_at", acc, 6); chk("b2b_ld0", d, 24'h1);
    xfer(0, 1'b0, 16'd1, 24'h0, d, e, k, n); acc += k;
    chk("b2b_rsp3_at", acc, 9); chk("b2b_ld1", d, 24'h0);
    idle(0);

    // range: first illegal address, aliasing address, last legal address
    xfer(0, 1'b0, 16'd5, 24'h0, d, e, k, n); idle(0);
    xfer(0, 1'b0, 16'd1024, 24'h0, d, e, k, n);
    chk("oor_ld_lat", k, 3); chk("oor_ld_err", e, 1'b1); chk("oor_ld_data", d, 24'h0);
    idle(0);
    xfer(0, 1'b1, 16'd1024, 24'h555555, d, e, k, n);
    chk("oor_st_err", e, 1'b1); idle(0);
    xfer(0, 1'b1, 16'd1029, 24'h777777, d, e, k, n);
    chk("oor_alias_err", e, 1'b1); idle(0);
    xfer(0, 1'b0, 16'd5, 24'h0, d, e, k, n);
    chk("no_wrap_ld5", d, 24'hABCDEF); idle(0);
    xfer(0, 1'b1, 16'd1023, 24'h3FF3FF, d, e, k, n);
    chk("top_st_err", e, 1'b0); idle(0);
    xfer(0, 1'b0, 16'd1023, 24'h0, d, e, k, n);
    chk("top_ld_data", d, 24'h3FF3FF); chk("top_ld_err", e, 1'b0); idle(0);
`ifndef BTN_MMIO_EN
    xfer(0, 1'b0, 16'hFFFF, 24'h0, d, e, k, n);
    chk("ffff_err", e, 1'b1); chk("ffff_data", d, 24'h0); idle(0);
`endif

    // reset during BUSY aborts the store
    xfer(0, 1'b1, 16'd7, 24'h111111, d, e, k, n); idle(0);
    rv[0] = 1'b1; rwe[0] = 1'b1; ra[0] = 16'd7; rwd[0] = 24'h123456;
    @(negedge clk);
    chk("abort_busy", stall[0], 1'b1);
    rst = 1'b1; rv[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("abort_stall", stall[0], 1'b0);
    chk("abort_valid0", rvld[0], 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_valid", rvld[0], 1'b0);
    end
    xfer(0, 1'b0, 16'd7, 24'h0, d, e, k, n);
    chk("abort_ld7", d, 24'h111111); idle(0);

    // LATENCY 1 and 4 instances
    xfer(1, 1'b1, 16'd3, 24'hAAAAAA, d, e, k, n);
    chk("l1_st_lat", k, 2); chk("l1_st_stall", n, 1); idle(1);
    xfer(1, 1'b0, 16'd3, 24'h0, d, e, k, n);
    chk("l1_ld_lat", k, 2); chk("l1_ld_data", d, 24'hAAAAAA); idle(1);
    xfer(2, 1'b1, 16'd3, 24'hBBBBBB, d, e, k, n);
    chk("l4_st_lat", k, 5); chk("l4_st_stall", n, 4); idle(2);
    xfer(2, 1'b0, 16'd3, 24'h0, d, e, k, n);
    chk("l4_ld_lat", k, 5); chk("l4_ld_data", d, 24'hBBBBBB); idle(2);

`ifdef BTN_MMIO_EN
    // button MMIO: pulse btn[2], read sticky rise, read again cleared
    btn = 4'b0100;
    repeat (3) @(negedge clk);
    btn = 4'b0000;
    repeat (4) @(negedge clk);
    xfer(0, 1'b0, 16'hFFFF, 24'h0, d, e, k, n);
    chk("btn_ld1", d, 24'h000040); chk("btn_err", e, 1'b0); idle(0);
    xfer(0, 1'b0, 16'hFFFF, 24'h0, d, e, k, n);
    chk("btn_ld2", d, 24'h000000); idle(0);
    xfer(0, 1'b1, 16'hFFFF, 24'h123456, d, e, k, n);
    chk("btn_st_err", e, 1'b0); idle(0);
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
